// File: rtl/processor_pkg.sv
// Shared processor constants and register-file state encodings.
package processor_pkg;

    localparam int REGISTER_ADDRESS_WIDTH = 6;
    localparam int DATA_WIDTH             = 32;
    localparam int ZERO_REGISTER          = 0;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } rf_state_e;

    typedef enum logic {
        DEBUG_IDLE    = 1'b0,
        DEBUG_RESPOND = 1'b1
    } debug_state_e;

endpackage

// File: rtl/register_file_clear_sequencer.sv
// Post-reset clear sequencer: walks entries 1..DEPTH-1 writing zero, then
// switches to RUN and raises ready.
module register_file_clear_sequencer #(
    parameter int ADDRESS_WIDTH = processor_pkg::REGISTER_ADDRESS_WIDTH
) (
    input  logic                     clock,
    input  logic                     reset_n,
    output logic                     clear_write_enable,
    output logic [ADDRESS_WIDTH-1:0] clear_write_address,
    output logic                     ready
);
    import processor_pkg::*;

    localparam logic [ADDRESS_WIDTH-1:0] LAST_ENTRY  = '1;
    localparam logic [ADDRESS_WIDTH-1:0] FIRST_ENTRY = ADDRESS_WIDTH'(1);

    rf_state_e                state_q;
    rf_state_e                state_d;
    logic [ADDRESS_WIDTH-1:0] clear_counter_q;
    logic [ADDRESS_WIDTH-1:0] clear_counter_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= CLEAR;
            clear_counter_q <= FIRST_ENTRY;
        end else begin
            state_q         <= state_d;
            clear_counter_q <= clear_counter_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        clear_counter_d = clear_counter_q;
        if (state_q == CLEAR) begin
            clear_counter_d = clear_counter_q + 1'b1;
            if (clear_counter_q == LAST_ENTRY) begin
                state_d = RUN;
            end
        end
    end

    always_comb begin
        clear_write_enable  = (state_q == CLEAR);
        clear_write_address = clear_counter_q;
        ready               = (state_q == RUN);
    end

endmodule

// File: rtl/register_file.sv
// 64x32 register file: two combinational read ports, one write port, zeroing
// sequencer after reset and a debug snoop port. Optional write-through
// bypass enabled by defining REGISTER_FILE_WRITE_BYPASS_EN.
module register_file #(
    parameter int DATA_WIDTH    = processor_pkg::DATA_WIDTH,
    parameter int ADDRESS_WIDTH = processor_pkg::REGISTER_ADDRESS_WIDTH
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [ADDRESS_WIDTH-1:0] read_address_1,
    input  logic [ADDRESS_WIDTH-1:0] read_address_2,
    output logic [DATA_WIDTH-1:0]    read_value_1,
    output logic [DATA_WIDTH-1:0]    read_value_2,
    input  logic [ADDRESS_WIDTH-1:0] write_address,
    input  logic [DATA_WIDTH-1:0]    write_value,
    input  logic                     write_enable,
    output logic                     ready,
    input  logic                     debug_request,
    input  logic [ADDRESS_WIDTH-1:0] debug_address,
    output logic                     debug_ack,
    output logic [DATA_WIDTH-1:0]    debug_value
);
    import processor_pkg::*;

    localparam int DEPTH = 2 ** ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH-1:0] ZERO_ADDRESS = ADDRESS_WIDTH'(ZERO_REGISTER);

    logic [DATA_WIDTH-1:0]    entries_q [DEPTH];
    logic                     clear_write_enable;
    logic [ADDRESS_WIDTH-1:0] clear_write_address;
    logic                     array_write_enable;
    logic [ADDRESS_WIDTH-1:0] array_write_address;
    logic [DATA_WIDTH-1:0]    array_write_value;
    logic                     bypass_1;
    logic                     bypass_2;
    logic                     bypass_debug;
    logic [DATA_WIDTH-1:0]    debug_lookup;

    debug_state_e             debug_state_q;
    debug_state_e             debug_state_d;
    logic                     debug_ack_q;
    logic                     debug_ack_d;
    logic [DATA_WIDTH-1:0]    debug_value_q;
    logic [DATA_WIDTH-1:0]    debug_value_d;

    register_file_clear_sequencer #(
        .ADDRESS_WIDTH(ADDRESS_WIDTH)
    ) u_clear_sequencer (
        .clock              (clock),
        .reset_n            (reset_n),
        .clear_write_enable (clear_write_enable),
        .clear_write_address(clear_write_address),
        .ready              (ready)
    );

    // The sequencer owns the write port until ready; pipeline writes are dropped meanwhile.
    always_comb begin
        array_write_enable  = 1'b0;
        array_write_address = write_address;
        array_write_value   = write_value;
        if (!ready) begin
            array_write_enable  = clear_write_enable;
            array_write_address = clear_write_address;
            array_write_value   = '0;
        end else if (write_enable && (write_address != ZERO_ADDRESS)) begin
            array_write_enable = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (array_write_enable) begin
            entries_q[array_write_address] <= array_write_value;
        end
    end

`ifdef REGISTER_FILE_WRITE_BYPASS_EN
    logic write_hits;
    always_comb begin
        write_hits   = write_enable && ready && (write_address != ZERO_ADDRESS);
        bypass_1     = write_hits && (read_address_1 == write_address);
        bypass_2     = write_hits && (read_address_2 == write_address);
        bypass_debug = write_hits && (debug_address == write_address);
    end
`else
    always_comb begin
        bypass_1     = 1'b0;
        bypass_2     = 1'b0;
        bypass_debug = 1'b0;
    end
`endif

    always_comb begin
        read_value_1 = '0;
        read_value_2 = '0;
        debug_lookup = '0;
        if (ready && (read_address_1 != ZERO_ADDRESS)) begin
            read_value_1 = bypass_1 ? write_value : entries_q[read_address_1];
        end
        if (ready && (read_address_2 != ZERO_ADDRESS)) begin
            read_value_2 = bypass_2 ? write_value : entries_q[read_address_2];
        end
        if (ready && (debug_address != ZERO_ADDRESS)) begin
            debug_lookup = bypass_debug ? write_value : entries_q[debug_address];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            debug_state_q <= DEBUG_IDLE;
            debug_ack_q   <= 1'b0;
            debug_value_q <= '0;
        end else begin
            debug_state_q <= debug_state_d;
            debug_ack_q   <= debug_ack_d;
            debug_value_q <= debug_value_d;
        end
    end

    // RESPOND waits for the request level to drop so a held request acks only once.
    always_comb begin
        debug_state_d = debug_state_q;
        case (debug_state_q)
            DEBUG_IDLE: begin
                if (debug_request && ready) begin
                    debug_state_d = DEBUG_RESPOND;
                end
            end
            DEBUG_RESPOND: begin
                if (!debug_request) begin
                    debug_state_d = DEBUG_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        debug_ack_d   = 1'b0;
        debug_value_d = debug_value_q;
        if ((debug_state_q == DEBUG_IDLE) && debug_request && ready) begin
            debug_ack_d   = 1'b1;
            debug_value_d = debug_lookup;
        end
    end

    assign debug_ack   = debug_ack_q;
    assign debug_value = debug_value_q;

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file.
module tb_register_file;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [5:0]  read_address_1;
    logic [5:0]  read_address_2;
    logic [31:0] read_value_1;
    logic [31:0] read_value_2;
    logic [5:0]  write_address;
    logic [31:0] write_value;
    logic        write_enable;
    logic        ready;
    logic        debug_request;
    logic [5:0]  debug_address;
    logic        debug_ack;
    logic [31:0] debug_value;

    int checks = 0;
    int errors = 0;

    register_file dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .read_address_1(read_address_1),
        .read_address_2(read_address_2),
        .read_value_1  (read_value_1),
        .read_value_2  (read_value_2),
        .write_address (write_address),
        .write_value   (write_value),
        .write_enable  (write_enable),
        .ready         (ready),
        .debug_request (debug_request),
        .debug_address (debug_address),
        .debug_ack     (debug_ack),
        .debug_value   (debug_value)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_ready(output int cycles);
        cycles = 0;
        while (!ready && cycles < 200) begin
            tick();
            cycles++;
        end
    endtask

    task automatic write_reg(input logic [5:0] address, input logic [31:0] value);
        write_address = address;
        write_value   = value;
        write_enable  = 1'b1;
        tick();
        write_enable  = 1'b0;
    endtask

    task automatic test_reset();
        int cycles;
        reset_n = 1'b0;
        #2;
        checks++;
        if (ready !== 1'b0 || debug_ack !== 1'b0 || debug_value !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got ready=%b ack=%b value=%h expected 0 0 0", ready, debug_ack, debug_value);
        end
        tick();
        tick();
        reset_n = 1'b1;
        wait_ready(cycles);
        checks++;
        if (cycles !== 63) begin
            errors++;
            $display("[TB] FAIL first_clear_length: got %0d expected 63", cycles);
        end
        write_reg(6'd3, 32'hBAD0_0003);
        write_reg(6'd40, 32'hBAD0_0040);
        write_reg(6'd63, 32'hBAD0_0063);
        read_address_1 = 6'd40;
        #1;
        checks++;
        if (read_value_1 !== 32'hBAD0_0040) begin
            errors++;
            $display("[TB] FAIL garbage_preload: got %h expected bad00040", read_value_1);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ready_drop: got %b expected 0", ready);
        end
        tick();
        reset_n = 1'b1;
        read_address_1 = 6'd63;
        #1;
        checks++;
        if (read_value_1 !== 32'h0) begin
            errors++;
            $display("[TB] FAIL read_during_clear: got %h expected 0", read_value_1);
        end
        wait_ready(cycles);
        checks++;
        if (cycles !== 63) begin
            errors++;
            $display("[TB] FAIL clear_length: got %0d expected 63", cycles);
        end
        for (int i = 0; i < 64; i++) begin
            read_address_1 = 6'(i);
            read_address_2 = 6'(63 - i);
            #1;
            checks++;
            if (read_value_1 !== 32'h0 || read_value_2 !== 32'h0) begin
                errors++;
                $display("[TB] FAIL sweep_zero: addr %0d/%0d got %h/%h expected 0/0", i, 63 - i, read_value_1, read_value_2);
            end
        end
    endtask

    task automatic test_write_read();
        write_reg(6'd5, 32'hDEAD_BEEF);
        write_reg(6'd63, 32'h1234_5678);
        write_reg(6'd0, 32'hFFFF_FFFF);
        read_address_1 = 6'd5;
        read_address_2 = 6'd63;
        #1;
        checks++;
        if (read_value_1 !== 32'hDEAD_BEEF || read_value_2 !== 32'h1234_5678) begin
            errors++;
            $display("[TB] FAIL write_read: got %h/%h expected deadbeef/12345678", read_value_1, read_value_2);
        end
        read_address_1 = 6'd0;
        read_address_2 = 6'd5;
        #1;
        checks++;
        if (read_value_1 !== 32'h0 || read_value_2 !== 32'hDEAD_BEEF) begin
            errors++;
            $display("[TB] FAIL zero_register: got %h/%h expected 0/deadbeef", read_value_1, read_value_2);
        end
        read_address_1 = 6'd5;
        #1;
        checks++;
        if (read_value_1 !== 32'hDEAD_BEEF) begin
            errors++;
            $display("[TB] FAIL same_address_ports: got %h expected deadbeef", read_value_1);
        end
    endtask

    task automatic test_write_during_clear();
        int cycles;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        write_reg(6'd7, 32'h0000_00AA);
        tick();
        write_reg(6'd1, 32'h0000_00AA);
        wait_ready(cycles);
        checks++;
        if (cycles !== 58) begin
            errors++;
            $display("[TB] FAIL clear_remaining: got %0d expected 58", cycles);
        end
        read_address_1 = 6'd7;
        read_address_2 = 6'd1;
        #1;
        checks++;
        if (read_value_1 !== 32'h0 || read_value_2 !== 32'h0) begin
            errors++;
            $display("[TB] FAIL write_during_clear: got %h/%h expected 0/0", read_value_1, read_value_2);
        end
    endtask

    task automatic test_same_cycle();
        logic [31:0] expected_now;
`ifdef REGISTER_FILE_WRITE_BYPASS_EN
        expected_now = 32'h55;
`else
        expected_now = 32'h0;
`endif
        read_address_1 = 6'd9;
        read_address_2 = 6'd9;
        write_address  = 6'd9;
        write_value    = 32'h55;
        write_enable   = 1'b1;
        #1;
        checks++;
        if (read_value_1 !== expected_now || read_value_2 !== expected_now) begin
            errors++;
            $display("[TB] FAIL same_cycle_read: got %h/%h expected %h", read_value_1, read_value_2, expected_now);
        end
        tick();
        write_enable = 1'b0;
        #1;
        checks++;
        if (read_value_1 !== 32'h55) begin
            errors++;
            $display("[TB] FAIL next_cycle_read: got %h expected 55", read_value_1);
        end
    endtask

    task automatic test_debug();
        int acks;
        logic [31:0] expected_capture;
        write_reg(6'd12, 32'h0000_CAFE);
        debug_address = 6'd12;
        debug_request = 1'b1;
        acks = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (debug_ack === 1'b1) acks++;
            if (i == 0) begin
                checks++;
                if (debug_ack !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL debug_latency: got ack=%b expected 1", debug_ack);
                end
            end
        end
        checks++;
        if (acks !== 1 || debug_value !== 32'h0000_CAFE) begin
            errors++;
            $display("[TB] FAIL debug_single_ack: got %0d acks value %h expected 1 acks value cafe", acks, debug_value);
        end
        debug_request = 1'b0;
        tick();
        tick();
        checks++;
        if (debug_ack !== 1'b0 || debug_value !== 32'h0000_CAFE) begin
            errors++;
            $display("[TB] FAIL debug_hold: got ack=%b value=%h expected 0 cafe", debug_ack, debug_value);
        end
        debug_address = 6'd0;
        debug_request = 1'b1;
        tick();
        checks++;
        if (debug_ack !== 1'b1 || debug_value !== 32'h0) begin
            errors++;
            $display("[TB] FAIL debug_zero: got ack=%b value=%h expected 1 0", debug_ack, debug_value);
        end
        debug_request = 1'b0;
        tick();
        write_reg(6'd20, 32'h11);
`ifdef REGISTER_FILE_WRITE_BYPASS_EN
        expected_capture = 32'h22;
`else
        expected_capture = 32'h11;
`endif
        debug_address = 6'd20;
        debug_request = 1'b1;
        write_reg(6'd20, 32'h22);
        checks++;
        if (debug_ack !== 1'b1 || debug_value !== expected_capture) begin
            errors++;
            $display("[TB] FAIL debug_write_collision: got ack=%b value=%h expected 1 %h", debug_ack, debug_value, expected_capture);
        end
        debug_request = 1'b0;
        tick();
    endtask

    task automatic test_debug_during_clear();
        int cycles;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        debug_address = 6'd12;
        debug_request = 1'b1;
        cycles = 0;
        while (debug_ack !== 1'b1 && cycles < 200) begin
            tick();
            cycles++;
        end
        checks++;
        if (cycles !== 64 || debug_value !== 32'h0) begin
            errors++;
            $display("[TB] FAIL debug_during_clear: got ack after %0d cycles value %h expected 64 cycles value 0", cycles, debug_value);
        end
        debug_request = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_operation();
        int cycles;
        write_reg(6'd12, 32'h0000_CAFE);
        debug_address = 6'd12;
        debug_request = 1'b1;
        tick();
        checks++;
        if (debug_ack !== 1'b1 || debug_value !== 32'h0000_CAFE) begin
            errors++;
            $display("[TB] FAIL pre_reset_ack: got ack=%b value=%h expected 1 cafe", debug_ack, debug_value);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (debug_ack !== 1'b0 || debug_value !== 32'h0 || ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid_debug: got ack=%b value=%h ready=%b expected 0 0 0", debug_ack, debug_value, ready);
        end
        debug_request = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 29; i++) tick();
        debug_request = 1'b1;
        tick();
        checks++;
        if (debug_ack !== 1'b0 || ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL request_held_off: got ack=%b ready=%b expected 0 0", debug_ack, ready);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b0 || debug_ack !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid_clear: got ready=%b ack=%b expected 0 0", ready, debug_ack);
        end
        debug_request = 1'b0;
        tick();
        reset_n = 1'b1;
        wait_ready(cycles);
        checks++;
        if (cycles !== 63) begin
            errors++;
            $display("[TB] FAIL clear_restart: got %0d expected 63", cycles);
        end
        tick();
        tick();
        read_address_1 = 6'd12;
        #1;
        checks++;
        if (debug_ack !== 1'b0 || read_value_1 !== 32'h0) begin
            errors++;
            $display("[TB] FAIL request_dropped: got ack=%b entry12=%h expected 0 0", debug_ack, read_value_1);
        end
    endtask

    initial begin
        reset_n        = 1'b0;
        read_address_1 = '0;
        read_address_2 = '0;
        write_address  = '0;
        write_value    = '0;
        write_enable   = 1'b0;
        debug_request  = 1'b0;
        debug_address  = '0;
        test_reset();
        test_write_read();
        test_write_during_clear();
        test_same_cycle();
        test_debug();
        test_debug_during_clear();
        test_reset_mid_operation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- 64-entry x 32-bit architectural register file feeding the decode stage of `processor`.
- Two combinational read ports and one synchronous write port, driven by the writeback stage.
- Entry 0 is hardwired to zero.
- After reset, a clear sequencer zeroes the array one entry per cycle and then raises `ready`.
- A request/acknowledge debug port lets the test harness snoop any entry without disturbing the pipeline.

Parameters:
- DATA_WIDTH, 32, width of each entry.
- ADDRESS_WIDTH, 6, address width; DEPTH = 2**ADDRESS_WIDTH.

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- read_address_1  input  ADDRESS_WIDTH  read port 1 address.
- read_address_2  input  ADDRESS_WIDTH  read port 2 address.
- read_value_1  output  DATA_WIDTH  combinational read data, port 1.
- read_value_2  output  DATA_WIDTH  combinational read data, port 2.
- write_address  input  ADDRESS_WIDTH  write address.
- write_value  input  DATA_WIDTH  write data.
- write_enable  input  1  write strobe, sampled on the rising clock edge.
- ready  output  1  high once the clear sequence is complete.
- debug_request  input  1  snoop request, level, held until acknowledged.
- debug_address  input  ADDRESS_WIDTH  snoop address, stable while debug_request is high.
- debug_ack  output  1  one-cycle pulse; debug_value is valid in the same cycle.
- debug_value  output  DATA_WIDTH  snooped data, held until the next acknowledge.

Behaviour:
- Reset (asynchronous, reset_n low):
  - State becomes CLEAR; clear_counter = 1.
  - ready = 0, debug_ack = 0, debug_value = 0.
  - Array contents are not reset directly; the sequencer zeroes them.
- State CLEAR:
  - Each cycle, write 0 to entry clear_counter, then increment.
  - When clear_counter = DEPTH-1 is written, go to RUN next cycle. CLEAR therefore lasts DEPTH-1 = 63 cycles.
  - ready rises in the first RUN cycle.
  - write_enable is ignored throughout CLEAR.
  - Both read ports return 0 throughout CLEAR.
- State RUN:
  - On a rising edge with write_enable = 1 and write_address != 0, the entry takes write_value.
  - Writes to address 0 are discarded.
- Reads:
  - read_value_n = 0 when read_address_n = 0; otherwise the stored entry.
  - Purely combinational, zero latency.
  - Both ports may read the same address.
  - A read of the address being written in the same cycle returns the old value (bypass disabled).
- Debug FSM (IDLE, RESPOND):
  - IDLE: if debug_request and ready, capture entry[debug_address] into debug_value, pulse debug_ack, go to RESPOND.
  - RESPOND: wait for debug_request to be low, then return to IDLE. This gives one acknowledge per request level; a held request is not re-acknowledged.
  - Latency: debug_ack is asserted on the cycle after the first edge at which debug_request is sampled high with ready = 1.
  - A request raised during CLEAR is held off until ready.
  - Debug capture in the same cycle as a write to the same address captures the pre-write value.
  - Address 0 always returns 0.
- Reset mid-operation: the clear sequence restarts from entry 1, ready drops immediately, and any pending debug request is dropped; the requester must re-raise it.

Optional Feature:
- Macro: REGISTER_FILE_WRITE_BYPASS_EN.
- Defined: when write_enable = 1, ready = 1, write_address != 0 and read_address_n = write_address, read_value_n = write_value in the same cycle (write-through). The debug capture also sees the bypassed value.
- Undefined: old value returned as above. The processor's writeback forwarding covers this case, so the feature is off by default.

Decomposition:
- Shared package (processor_pkg) holds:
  - REGISTER_ADDRESS_WIDTH = 6 and DATA_WIDTH = 32.
  - Register-file FSM state encodings: CLEAR = 1'b0, RUN = 1'b1; DEBUG_IDLE, DEBUG_RESPOND.
  - ZERO_REGISTER = 0.
- Sub-module: register_file_clear_sequencer, which owns clear_counter, the CLEAR/RUN state and ready, and outputs clear write address/enable. The array, read muxes and debug FSM stay in register_file.

Test Plan:
- Reset then sweep: release reset_n; ready = 0 for 63 cycles then 1; read every address -> all 0, including entries pre-loaded with garbage before reset.
- Write/read: write 0xDEADBEEF to 5 and 0x12345678 to 63 -> read_value_1(5) = 0xDEADBEEF, read_value_2(63) = 0x12345678 the cycle after; write 0xFFFFFFFF to 0 -> read 0 = 0.
- Write during CLEAR: write_enable = 1, address 7, value 0xAA at clear cycle 3 -> entry 7 reads 0 after ready.
- Same-cycle read/write: write 0x55 to 9 while reading 9 -> 0 (old value) without the macro, 0x55 with REGISTER_FILE_WRITE_BYPASS_EN; 0x55 on the next cycle either way.
- Debug handshake: entry 12 = 0xCAFE, hold request with address 12 for 5 cycles -> exactly one debug_ack pulse, debug_value = 0xCAFE held; request during CLEAR -> acknowledged on the cycle after ready rises.
- Reset mid-clear and mid-debug: assert reset_n low at clear cycle 30 with a request pending -> ready = 0 and debug_ack = 0 immediately; the full 63-cycle clear repeats.
